char_buffer: RTL

Character-cell store at the receiving end of the text-write strobe interface (addr / data / active-low nWr) that the display controller uses to post score digits. It accepts those writes and holds an 80×30 screen of 8-bit character codes. It serves a registered read port addressed by the sync generator's pixel position (hp/vp), which feeds the font/pixel stage. On reset or request it self-clears to spaces.

---
 rtl/char_buffer_pkg.sv | 19 +
 rtl/char_ram.sv | 18 +
 rtl/char_buffer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/char_buffer_pkg.sv
// txt_pkg: shared geometry, cell constants and FSM state type for the character buffer
package txt_pkg;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CHAR_W = 8;
  localparam int CHAR_H = 16;
  localparam logic [7:0] BLANK_CHAR = 8'h20;
  localparam int TXT_ADDR_W = 12;
  localparam int TXT_CELLS = COLS * ROWS;
  localparam logic [TXT_ADDR_W-1:0] P1_SCORE_ADDR = 12'h05C;
  localparam logic [TXT_ADDR_W-1:0] P2_SCORE_ADDR = 12'h06B;
  localparam logic [TXT_ADDR_W-1:0] LAST_CELL = 12'(TXT_CELLS - 1);
  localparam logic [TXT_ADDR_W-1:0] CELL_LIMIT = 12'(TXT_CELLS);
  localparam logic [10:0] H_ACTIVE = 11'(COLS * CHAR_W);
  localparam logic [9:0] V_ACTIVE = 10'(ROWS * CHAR_H);
  localparam int CW_SH = $clog2(CHAR_W);
  localparam int CH_SH = $clog2(CHAR_H);
  typedef enum logic [1:0] {IDLE, CLEAR, FLUSH} state_t;
endpackage

// File: rtl/char_ram.sv
// char_ram: simple dual-port cell store, registered read returning old data on collision
module char_ram
  import txt_pkg::*;
(
  input  logic                  clk,
  input  logic                  we,
  input  logic [TXT_ADDR_W-1:0] waddr,
  input  logic [7:0]            wdata,
  input  logic [TXT_ADDR_W-1:0] raddr,
  output logic [7:0]            q
);
  logic [7:0] mem [0:TXT_CELLS-1];
  // one write and one registered read per cycle; the read samples the pre-write contents
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    q <= mem[raddr];
  end
endmodule

// File: rtl/char_buffer.sv
// char_buffer: strobe-written 80x30 character store with self-clear and a 2-cycle pixel read port
module char_buffer
  import txt_pkg::*;
(
  input  logic                  iVGA_CLK,
  input  logic                  reset,
  input  logic [TXT_ADDR_W-1:0] addr,
  input  logic [7:0]            data,
  input  logic                  nWr,
  input  logic                  clr_req,
  input  logic [10:0]           hp,
  input  logic [9:0]            vp,
  input  logic                  nblnk,
  output logic [7:0]            char_code,
  output logic [3:0]            glyph_row,
  output logic [2:0]            glyph_col,
  output logic                  char_valid,
  output logic                  busy,
  output logic                  wr_err
);
  state_t state, state_d;
  logic nwr_q, cap_vld, cap_ok, cap_err;
  logic [TXT_ADDR_W-1:0] cap_addr, pend_addr, clr_cnt, ram_wa, rd_addr, lin;
  logic [7:0] cap_data, pend_data, ram_wd, ram_q, col;
  logic [5:0] row;
  logic pend_vld, ram_we, to_pend, pend_clr, oor, oor1, oor2;
  logic [3:0] grow1;
  logic [2:0] gcol1;
  assign cap_ok = cap_vld & (cap_addr < CELL_LIMIT);
  assign cap_err = cap_vld & ~cap_ok;
  assign busy = state != IDLE;
  // falling-edge strobe detect; addr/data are captured every cycle and used only behind cap_vld
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      nwr_q <= 1'b1;
      cap_vld <= 1'b0;
    end else begin
      nwr_q <= nWr;
      cap_vld <= nwr_q & ~nWr;
    end
    cap_addr <= addr;
    cap_data <= data;
  end
  // state register, clear counter, pending slot and sticky error
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      state <= CLEAR;
      clr_cnt <= '0;
      pend_vld <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      state <= state_d;
      clr_cnt <= (state == CLEAR) ? clr_cnt + 12'd1 : '0;
      if (to_pend) pend_vld <= 1'b1;
      else if (pend_clr) pend_vld <= 1'b0;
      if (cap_err | (to_pend & pend_vld & ~pend_clr)) wr_err <= 1'b1;
    end
    if (to_pend) begin
      pend_addr <= cap_addr;
      pend_data <= cap_data;
    end
  end
  // next state and write-port steering: clear owns the port, then pending, then live strobes
  always_comb begin
    state_d = state;
    ram_we = 1'b0;
    ram_wa = cap_addr;
    ram_wd = cap_data;
    to_pend = 1'b0;
    pend_clr = 1'b0;
    case (state)
      CLEAR: begin
        ram_we = 1'b1;
        ram_wa = clr_cnt;
        ram_wd = BLANK_CHAR;
        to_pend = cap_ok;
        state_d = (clr_cnt == LAST_CELL) ? FLUSH : CLEAR;
      end
      FLUSH: begin
        state_d = IDLE;
        ram_we = pend_vld | cap_ok;
        ram_wa = pend_vld ? pend_addr : cap_addr;
        ram_wd = pend_vld ? pend_data : cap_data;
        pend_clr = pend_vld;
        to_pend = pend_vld & cap_ok;
      end
      IDLE: begin
        state_d = clr_req ? CLEAR : IDLE;
        ram_we = cap_ok | pend_vld;
        ram_wa = cap_ok ? cap_addr : pend_addr;
        ram_wd = cap_ok ? cap_data : pend_data;
        pend_clr = ~cap_ok & pend_vld;
      end
      default: state_d = CLEAR;
    endcase
  end
  assign col = 8'(hp >> CW_SH);
  assign row = 6'(vp >> CH_SH);
  assign lin = {row, 6'b0} + {2'b0, row, 4'b0} + {4'b0, col};
  assign oor = (hp >= H_ACTIVE) | (vp >= V_ACTIVE) | ~nblnk;
  // read pipeline: stage 1 address/flags, stage 2 RAM output with flags piped alongside
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      rd_addr <= '0;
      oor1 <= 1'b1;
      oor2 <= 1'b1;
      grow1 <= '0;
      gcol1 <= '0;
      glyph_row <= '0;
      glyph_col <= '0;
    end else begin
      rd_addr <= oor ? '0 : lin;
      oor1 <= oor;
      oor2 <= oor1;
      grow1 <= vp[CH_SH-1:0];
      gcol1 <= hp[CW_SH-1:0];
      glyph_row <= grow1;
      glyph_col <= gcol1;
    end
  end
  assign char_code = oor2 ? BLANK_CHAR : ram_q;
  assign char_valid = ~oor2;
  char_ram u_ram (
    .clk(iVGA_CLK),
    .we(ram_we),
    .waddr(ram_wa),
    .wdata(ram_wd),
    .raddr(rd_addr),
    .q(ram_q)
  );
endmodule
